// File: rtl/dp_pkg.sv
// Shared encodings, command payload and sign-extension helpers for the
// self-sequencing datapath.
package dp_pkg;

   localparam int unsigned SX_MAX_W = 64;

   localparam logic [2:0] CMD_MOVI = 3'd0;
   localparam logic [2:0] CMD_MOVR = 3'd1;
   localparam logic [2:0] CMD_ALU  = 3'd2;
   localparam logic [2:0] CMD_CMP  = 3'd3;
   localparam logic [2:0] CMD_LDM  = 3'd4;
   localparam logic [2:0] CMD_LPC  = 3'd5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RDA  = 3'd1;
   localparam logic [2:0] S_RDB  = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;

   typedef struct packed {
      logic [2:0] cmd;
      logic [1:0] alu_op;
      logic [1:0] shift;
      logic       use_imm;
      logic [4:0] imm5;
      logic [7:0] imm8;
   } cmd_ctl_t;

   // Widest sign extension; callers truncate to the datapath width.
   function automatic logic [SX_MAX_W-1:0] sx5(input logic [4:0] x);
      return SX_MAX_W'($signed(x));
   endfunction

   function automatic logic [SX_MAX_W-1:0] sx8(input logic [7:0] x);
      return SX_MAX_W'($signed(x));
   endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: one synchronous write port, one combinational read
// port, cleared by the asynchronous reset.
module dp_regfile #(
   parameter int unsigned W    = 16,
   parameter int unsigned NREG = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_we,
   input  logic [$clog2(NREG)-1:0]  i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(NREG)-1:0]  i_raddr,
   output logic [W-1:0]             o_rdata_c
);

   localparam int unsigned RW = $clog2(NREG);

   logic [W-1:0] r_mem [NREG];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            r_mem[RW'(i)] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B/C operands, shifter, ALU and
// N/Z/V flags, stepped through IDLE/RDA/RDB/EXEC/WB by an internal FSM.
module datapath_seq
   import dp_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter int unsigned NREG = 8,
   parameter int unsigned PCW  = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [2:0]              cmd,
   input  logic [1:0]              alu_op,
   input  logic [1:0]              shift,
   input  logic                    use_imm,
   input  logic [$clog2(NREG)-1:0] rn,
   input  logic [$clog2(NREG)-1:0] rm,
   input  logic [$clog2(NREG)-1:0] rd,
   input  logic [4:0]              imm5,
   input  logic [7:0]              imm8,
   input  logic [W-1:0]            mdata,
   input  logic [PCW-1:0]          pc,
   output logic                    ready,
   output logic                    done,
   output logic                    err,
   output logic [W-1:0]            result,
   output logic                    n_flag,
   output logic                    z_flag,
   output logic                    v_flag
);

   localparam int unsigned RW = $clog2(NREG);

   logic [2:0]     r_state;
   logic [2:0]     w_next;
   logic           r_ready;
   logic           r_done;
   logic           r_err;

   cmd_ctl_t       r_ctl;
   logic [RW-1:0]  r_rn;
   logic [RW-1:0]  r_rm;
   logic [RW-1:0]  r_rd;
   logic [W-1:0]   r_mdata;
   logic [PCW-1:0] r_pc;

   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_c;
   logic           r_n;
   logic           r_z;
   logic           r_v;

   logic           w_idle;
   logic           w_legal;
   logic           w_accept;
   logic [RW-1:0]  w_raddr;
   logic [W-1:0]   w_rdata;
   logic [W-1:0]   w_shifted;
   logic [W-1:0]   w_bop;
   logic [1:0]     w_op;
   logic [W-1:0]   w_sum;
   logic [W-1:0]   w_dif;
   logic [W-1:0]   w_alu;
   logic           w_ovf;
   logic           w_flag_ld;
   logic           w_we;
   logic [W-1:0]   w_wdata;

   assign w_idle   = (r_state == S_IDLE);
   assign w_legal  = (cmd <= CMD_LPC);
   assign w_accept = start && w_idle && w_legal;

   // State register plus registered status strobes derived from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == S_IDLE);
         r_done  <= (w_next == S_WB);
         r_err   <= start && w_idle && !w_legal;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (cmd)
                  CMD_ALU, CMD_CMP:          w_next = S_RDA;
                  CMD_MOVR:                  w_next = S_RDB;
                  CMD_MOVI, CMD_LDM, CMD_LPC: w_next = S_WB;
                  default:                   w_next = S_IDLE;
               endcase
            end
         end
         S_RDA:   w_next = S_RDB;
         S_RDB:   w_next = S_EXEC;
         S_EXEC:  w_next = S_WB;
         S_WB:    w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Command capture: the command is frozen at acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctl   <= '0;
         r_rn    <= '0;
         r_rm    <= '0;
         r_rd    <= '0;
         r_mdata <= '0;
         r_pc    <= '0;
      end else if (w_accept) begin
         r_ctl   <= '{cmd: cmd, alu_op: alu_op, shift: shift, use_imm: use_imm,
                      imm5: imm5, imm8: imm8};
         r_rn    <= rn;
         r_rm    <= rm;
         r_rd    <= rd;
         r_mdata <= mdata;
         r_pc    <= pc;
      end
   end

   assign w_raddr = (r_state == S_RDA) ? r_rn : r_rm;

   dp_regfile #(.W(W), .NREG(NREG)) u_regfile (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_we      (w_we),
      .i_waddr   (r_rd),
      .i_wdata   (w_wdata),
      .i_raddr   (w_raddr),
      .o_rdata_c (w_rdata)
   );

   // Shifter and B-operand select.
   always_comb begin
      w_shifted = r_b;
      case (r_ctl.shift)
         SH_LSL:  w_shifted = {r_b[W-2:0], 1'b0};
         SH_LSR:  w_shifted = {1'b0, r_b[W-1:1]};
         SH_ASR:  w_shifted = {r_b[W-1], r_b[W-1:1]};
         default: w_shifted = r_b;
      endcase
   end

   assign w_bop = r_ctl.use_imm ? W'(sx5(r_ctl.imm5)) : w_shifted;
   assign w_op  = (r_ctl.cmd == CMD_MOVR) ? OP_ADD : r_ctl.alu_op;
   assign w_sum = r_a + w_bop;
   assign w_dif = r_a - w_bop;

   always_comb begin
      w_alu = w_sum;
      w_ovf = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_alu = w_sum;
            w_ovf = (r_a[W-1] == w_bop[W-1]) && (w_sum[W-1] != r_a[W-1]);
         end
         OP_SUB: begin
            w_alu = w_dif;
            w_ovf = (r_a[W-1] != w_bop[W-1]) && (w_dif[W-1] != r_a[W-1]);
         end
         OP_AND:  w_alu = r_a & w_bop;
         default: w_alu = ~w_bop;
      endcase
   end

   assign w_flag_ld = (r_ctl.cmd == CMD_ALU) || (r_ctl.cmd == CMD_CMP);

   // Operand, result and flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= '0;
         r_n <= 1'b0;
         r_z <= 1'b0;
         r_v <= 1'b0;
      end else begin
         case (r_state)
            S_RDA: r_a <= w_rdata;
            S_RDB: begin
               r_b <= w_rdata;
               if (r_ctl.cmd == CMD_MOVR) begin
                  r_a <= '0;
               end
            end
            S_EXEC: begin
               r_c <= w_alu;
               if (w_flag_ld) begin
                  r_n <= w_alu[W-1];
                  r_z <= (w_alu == '0);
                  r_v <= w_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   // Write-back source; CMP only updates C and the flags.
   assign w_we = (r_state == S_WB) && (r_ctl.cmd != CMD_CMP);

   always_comb begin
      w_wdata = r_c;
      case (r_ctl.cmd)
         CMD_MOVI: w_wdata = W'(sx8(r_ctl.imm8));
         CMD_LDM:  w_wdata = r_mdata;
         CMD_LPC:  w_wdata = W'(r_pc);
         default:  w_wdata = r_c;
      endcase
   end

   assign ready  = r_ready;
   assign done   = r_done;
   assign err    = r_err;
   assign result = r_c;
   assign n_flag = r_n;
   assign z_flag = r_z;
   assign v_flag = r_v;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed steps plus randomized
// commands compared against an arithmetic reference model.
module tb_datapath_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  cmd = '0;
   logic [1:0]  alu_op = '0;
   logic [1:0]  shift = '0;
   logic        use_imm = 1'b0;
   logic [2:0]  rn = '0, rm = '0, rd = '0;
   logic [4:0]  imm5 = '0;
   logic [7:0]  imm8 = '0;
   logic [15:0] mdata = '0;
   logic [7:0]  pc = '0;
   logic        ready, done, err, n_flag, z_flag, v_flag;
   logic [15:0] result;

   logic        b_start = 1'b0;
   logic [2:0]  b_cmd = '0;
   logic [1:0]  b_shift = '0;
   logic [3:0]  b_rm = '0, b_rd = '0;
   logic [31:0] b_mdata = '0;
   logic [7:0]  b_pc = '0;
   logic        b_ready, b_done, b_err, b_n, b_z, b_v;
   logic [31:0] b_result;

   always #5 clk = ~clk;

   datapath_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .alu_op(alu_op),
      .shift(shift), .use_imm(use_imm), .rn(rn), .rm(rm), .rd(rd), .imm5(imm5),
      .imm8(imm8), .mdata(mdata), .pc(pc), .ready(ready), .done(done), .err(err),
      .result(result), .n_flag(n_flag), .z_flag(z_flag), .v_flag(v_flag)
   );

   datapath_seq #(.W(32), .NREG(16), .PCW(8)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(b_start), .cmd(b_cmd), .alu_op(2'b00),
      .shift(b_shift), .use_imm(1'b0), .rn(4'd0), .rm(b_rm), .rd(b_rd), .imm5(5'd0),
      .imm8(8'd0), .mdata(b_mdata), .pc(b_pc), .ready(b_ready), .done(b_done),
      .err(b_err), .result(b_result), .n_flag(b_n), .z_flag(b_z), .v_flag(b_v)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] m_r [8];
   logic [15:0] m_c;
   logic        m_n, m_z, m_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_c = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
   endtask

   // Reference: what each command does to architectural state, in plain arithmetic.
   task automatic model_exec(input logic [2:0] c, input logic [1:0] op, input logic [1:0] sh,
                             input logic ui, input logic [2:0] a_n, input logic [2:0] a_m,
                             input logic [2:0] a_d, input logic [4:0] i5, input logic [7:0] i8,
                             input logic [15:0] md, input logic [7:0] p,
                             output int lat, output bit ill);
      logic [15:0] a, b, res;
      int s;
      logic ov;
      ill = 1'b0; lat = 0; ov = 1'b0; res = '0;
      case (c)
         3'd0: begin m_r[a_d] = 16'($signed(i8)); lat = 1; end
         3'd4: begin m_r[a_d] = md; lat = 1; end
         3'd5: begin m_r[a_d] = {8'h00, p}; lat = 1; end
         3'd1, 3'd2, 3'd3: begin
            a = (c == 3'd1) ? 16'h0000 : m_r[a_n];
            b = m_r[a_m];
            case (sh)
               2'd1: b = 16'(b * 2);
               2'd2: b = b / 2;
               2'd3: b = 16'($signed(b) >>> 1);
               default: ;
            endcase
            if (ui) b = 16'($signed(i5));
            if (c == 3'd1) op = 2'd0;
            case (op)
               2'd0: begin s = int'($signed(a)) + int'($signed(b)); ov = (s > 32767) || (s < -32768); res = 16'(s); end
               2'd1: begin s = int'($signed(a)) - int'($signed(b)); ov = (s > 32767) || (s < -32768); res = 16'(s); end
               2'd2: res = a & b;
               default: res = ~b;
            endcase
            m_c = res;
            if (c != 3'd1) begin m_z = (res == 16'h0000); m_n = res[15]; m_v = ov; end
            if (c != 3'd3) m_r[a_d] = res;
            lat = (c == 3'd1) ? 3 : 4;
         end
         default: ill = 1'b1;
      endcase
   endtask

   task automatic scramble();
      cmd = 3'($urandom); alu_op = 2'($urandom); shift = 2'($urandom);
      use_imm = 1'($urandom); rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
      imm5 = 5'($urandom); imm8 = 8'($urandom); mdata = 16'($urandom); pc = 8'($urandom);
   endtask

   task automatic run(input string tag, input logic [2:0] c, input logic [1:0] op,
                      input logic [1:0] sh, input logic ui, input logic [2:0] a_n,
                      input logic [2:0] a_m, input logic [2:0] a_d, input logic [4:0] i5,
                      input logic [7:0] i8, input logic [15:0] md, input logic [7:0] p);
      int exp_lat, lat;
      bit ill;
      logic e1, e2;
      @(negedge clk);
      cmd = c; alu_op = op; shift = sh; use_imm = ui; rn = a_n; rm = a_m; rd = a_d;
      imm5 = i5; imm8 = i8; mdata = md; pc = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      model_exec(c, op, sh, ui, a_n, a_m, a_d, i5, i8, md, p, exp_lat, ill);
      e1 = err; e2 = 1'b0; lat = 0;
      if (done) lat = 1;
      for (int k = 2; k <= 8 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (k == 2) e2 = err;
         if (done) lat = k;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/err"}, {31'd0, e1}, {31'd0, ill});
      if (ill) chk({tag, "/err_width"}, {31'd0, e2}, 32'd0);
      if (!ill) begin @(posedge clk); #1; end
      chk({tag, "/ready"}, {31'd0, ready}, 32'd1);
      chk({tag, "/result"}, {16'd0, result}, {16'd0, m_c});
      chk({tag, "/nzv"}, {29'd0, n_flag, z_flag, v_flag}, {29'd0, m_n, m_z, m_v});
   endtask

   task automatic rd_reg(input string tag, input logic [2:0] r);
      run(tag, 3'd1, 2'd0, 2'd0, 1'b0, 3'd0, r, r, 5'd0, 8'd0, 16'd0, 8'd0);
   endtask

   task automatic run32(input logic [2:0] c, input logic [1:0] sh, input logic [3:0] a_m,
                        input logic [3:0] a_d, input logic [31:0] md, input logic [7:0] p,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      b_cmd = c; b_shift = sh; b_rm = a_m; b_rd = a_d; b_mdata = md; b_pc = p; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      lat = b_done ? 1 : 0;
      for (int k = 2; k <= 8 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (b_done) lat = k;
      end
      @(posedge clk); #1;
      res = b_result;
   endtask

   initial begin
      int lat32, exp_lat;
      bit ill;
      logic [31:0] r32;
      logic [2:0] c;

      model_reset();
      #12;
      chk("reset/ready", {31'd0, ready}, 32'd1);
      chk("reset/done_err", {30'd0, done, err}, 32'd0);
      chk("reset/result", {16'd0, result}, 32'd0);
      chk("reset/nzv", {29'd0, n_flag, z_flag, v_flag}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run("movi", 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd3, 5'd0, 8'h80, 16'd0, 8'd0);
      run("movr", 3'd1, 2'd0, 2'd0, 1'b0, 3'd0, 3'd3, 3'd4, 5'd0, 8'd0, 16'd0, 8'd0);
      chk("movr/ff80", {16'd0, result}, 32'h0000_FF80);

      run("r1", 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd1, 5'd0, 8'd5, 16'd0, 8'd0);
      run("r2", 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd2, 5'd0, 8'd3, 16'd0, 8'd0);
      run("alu_add", 3'd2, 2'd0, 2'd1, 1'b0, 3'd1, 3'd2, 3'd0, 5'd0, 8'd0, 16'd0, 8'd0);
      chk("alu_add/11", {16'd0, result}, 32'd11);
      rd_reg("alu_add/r0", 3'd0);

      run("ldm", 3'd4, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd1, 5'd0, 8'd0, 16'h7FFF, 8'd0);
      run("cmp_ovf", 3'd3, 2'd1, 2'd0, 1'b1, 3'd1, 3'd0, 3'd5, 5'h1F, 8'd0, 16'd0, 8'd0);
      chk("cmp_ovf/nzv", {29'd0, n_flag, z_flag, v_flag}, 32'b101);
      rd_reg("cmp_ovf/r1", 3'd1);
      rd_reg("cmp_ovf/r5", 3'd5);

      run("illegal7", 3'd7, 2'd1, 2'd0, 1'b0, 3'd1, 3'd1, 3'd1, 5'd0, 8'h11, 16'd0, 8'd0);
      run("illegal6", 3'd6, 2'd0, 2'd0, 1'b0, 3'd2, 3'd2, 3'd2, 5'd0, 8'h22, 16'd0, 8'd0);
      rd_reg("illegal/r1", 3'd1);

      // Busy: a MOVI presented while the ALU command sits in RDB is dropped.
      @(negedge clk);
      cmd = 3'd2; alu_op = 2'd0; shift = 2'd0; use_imm = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd6;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_exec(3'd2, 2'd0, 2'd0, 1'b0, 3'd1, 3'd2, 3'd6, 5'd0, 8'd0, 16'd0, 8'd0, exp_lat, ill);
      @(posedge clk); #1;
      cmd = 3'd0; rd = 3'd5; imm8 = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy/no_early_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk("busy/done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("busy/ready", {31'd0, ready}, 32'd1);
      chk("busy/result", {16'd0, result}, {16'd0, m_c});
      rd_reg("busy/r5", 3'd5);
      rd_reg("busy/r6", 3'd6);

      // Reset while the ALU command is in EXEC.
      @(negedge clk);
      cmd = 3'd2; alu_op = 2'd0; shift = 2'd0; use_imm = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid/ready", {31'd0, ready}, 32'd1);
      chk("rst_mid/done_err", {30'd0, done, err}, 32'd0);
      chk("rst_mid/result", {16'd0, result}, 32'd0);
      chk("rst_mid/nzv", {29'd0, n_flag, z_flag, v_flag}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      rd_reg("rst_mid/r7", 3'd7);
      rd_reg("rst_mid/r1", 3'd1);

      // Randomized commands against the model.
      repeat (80) begin
         c = 3'($urandom_range(0, 9) > 7 ? 2 : $urandom_range(0, 7));
         run("rand", c, 2'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
             3'($urandom), 5'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 8; i++) rd_reg("rand/final", 3'(i));

      // Wide, 16-register instance.
      run32(3'd4, 2'd0, 4'd0, 4'd1, 32'h8000_0000, 8'd0, r32, lat32);
      chk("w32/ldm_lat", 32'(lat32), 32'd1);
      run32(3'd1, 2'd3, 4'd1, 4'd2, 32'd0, 8'd0, r32, lat32);
      chk("w32/asr", r32, 32'hC000_0000);
      chk("w32/movr_lat", 32'(lat32), 32'd3);
      run32(3'd1, 2'd1, 4'd2, 4'd3, 32'd0, 8'd0, r32, lat32);
      chk("w32/lsl", r32, 32'h8000_0000);
      run32(3'd5, 2'd0, 4'd0, 4'd15, 32'd0, 8'hAB, r32, lat32);
      chk("w32/lpc_lat", 32'(lat32), 32'd1);
      run32(3'd1, 2'd0, 4'd15, 4'd14, 32'd0, 8'd0, r32, lat32);
      chk("w32/lpc_zext", r32, 32'h0000_00AB);
      chk("w32/ready_err", {30'd0, b_ready, b_err}, 32'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised, self-sequencing successor to the lab datapath. It holds the register file, the A/B/C operand registers, the shifter, the ALU and the N/Z/V status flags. An internal state machine steps each command through read, execute and write-back, so the controller only issues a command with `start` and waits for `done`. It sits between the instruction decoder/controller and memory, and supplies `result` as the memory address and write data.

## Interface
- `W`, 16, datapath and register width (≥ 9)
- `NREG`, 8, number of general registers (power of 2); `RW = $clog2(NREG)`
- `PCW`, 8, program-counter width (≤ W)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: command strobe; accepted only while `ready`=1
- `cmd` in 3: 0 MOVI, 1 MOVR, 2 ALU, 3 CMP, 4 LDM, 5 LPC; 6–7 illegal
- `alu_op` in 2: 00 ADD, 01 SUB, 10 AND, 11 NOT B
- `shift` in 2: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- `use_imm` in 1: B operand = sximm5 instead of shifted R[rm]
- `rn`, `rm`, `rd` in RW each: source A, source B, destination
- `imm5` in 5, `imm8` in 8: immediates, sign-extended to W
- `mdata` in W: memory read data; `pc` in PCW: program counter
- `ready` out 1: high in IDLE
- `done` out 1: one-cycle pulse in the final (WB) cycle of a command
- `err` out 1: one-cycle pulse when an illegal `cmd` is started
- `result` out W: C register
- `n_flag`, `z_flag`, `v_flag` out 1: status registers

## Operation
- Command capture: on `start`&`ready`, all command fields plus `mdata` and `pc` are registered. Later input changes have no effect on that command.
- MOVI: R[rd] ← sx(imm8).
- LDM: R[rd] ← mdata.
- LPC: R[rd] ← zero-extended pc.
- MOVR: A ← 0; R[rd] ← C ← 0 + Bop (ADD forced).
- ALU: R[rd] ← C ← R[rn] op Bop; flags updated.
- CMP: C ← R[rn] − Bop; flags updated; no register write.
- Bop = `use_imm` ? sx(imm5) : shift(R[rm]). LSR1 fills 0; ASR1 replicates the MSB; LSL1 fills 0 at the LSB.
- Flags: Z = (ALU result == 0); N = result[W-1]; V = signed overflow for ADD/SUB, 0 for AND/NOT. Flags load only in EXEC of ALU and CMP.
- Arithmetic is modulo 2^W.
- Illegal cmd: `err` pulses in the next cycle, state stays IDLE, and no register, flag or C change.
- MOVI, LDM and LPC leave C and the flags untouched.
- rd may equal rn or rm; reads complete before the write.

## Timing
- States: IDLE → RDA → RDB → EXEC → WB → IDLE. ALU and CMP visit all states.
- MOVR skips RDA (IDLE → RDB).
- MOVI, LDM and LPC go IDLE → WB.
- Latency from the `start` edge to `done`: 4 cycles for ALU/CMP, 3 for MOVR, 1 for MOVI/LDM/LPC.
- The register write takes effect on the clock edge ending WB. `ready` rises in the following cycle; back-to-back issue is therefore possible one cycle after `done`.
- `start` while not `ready` is ignored, with no queueing.
- Reset (async, any state): state IDLE, all registers R, A, B and C = 0, flags = 0, `done`=`err`=0, `ready`=1. An in-flight command is aborted with no write.

## Structure
- Package `dp_pkg` holds the cmd, alu_op and shift encodings, the state enum, and the sign-extend function.
- Sub-module `dp_regfile #(W,NREG)` provides one write port and one combinational read port, with async reset to 0.
- The shifter, ALU and B mux are inline in `datapath_seq`.

## Test plan
- Reset then MOVI: MOVI rd=3 imm8=0x80 → `done` 1 cycle later; a following MOVR rd=4 rm=3 shift=00 gives `result`=0xFF80.
- ALU: R1=5, R2=3, ALU rd=0 rn=1 rm=2 shift=01 op=ADD → `done` at cycle 4, `result`=11, R0=11, Z=0, N=0, V=0.
- CMP overflow: R1=0x7FFF, CMP rn=1 imm5=−1 with op SUB → V=1, N=1, Z=0, registers unchanged.
- Illegal and busy: cmd=7 → `err` pulse with no state change; `start` during RDB → ignored, and the first command completes normally.
- Reset mid-ALU: assert `reset_n`=0 in EXEC → `ready`=1 and all outputs 0, no write to rd.
- Parameters: W=32, NREG=16 with ASR1 on 0x80000000 → 0xC0000000; LPC with pc=0xAB → 0x000000AB.
